instr_fetch_queue: RTL

//  Front-end fetch stage directly upstream of the instruction decoder. Holds the PC, issues

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/instr_fetch_queue.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

    localparam int INSTR_W   = 32;
    localparam int ADDR_W    = 32;
    localparam int PC_STEP   = 4;
    localparam int PC_OFFSET = 8;

    typedef enum logic {
        FETCH,
        FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  addr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with occupancy count, used for both the prefetch queue and the
// issued-address tag queue. Clear takes priority over push and pop.
module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  T                         din,
    output T                         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: holds the PC, issues imem reads, queues returned words for decode, and flushes on
// redirect. Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module instr_fetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rdy,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              dec_valid,
    output logic [31:0]       dec_instr,
    output logic [ADDR_W-1:0] dec_pc8,
    input  logic              dec_ready
);

    import fetch_pkg::*;

    localparam int                CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]    LIMIT      = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    fetch_state_e      state;
    fetch_state_e      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  outstanding_next;
    logic [CNT_W-1:0]  discard;
    logic [CNT_W-1:0]  discard_next;

    fq_entry_t         q_din;
    fq_entry_t         q_head;
    logic              q_push;
    logic              q_pop;
    logic              q_full;
    logic              q_empty;
    logic [CNT_W-1:0]  q_count;

    logic [ADDR_W-1:0] tag_head;
    logic              tag_full;
    logic              tag_empty;
    logic [CNT_W-1:0]  tag_count;

    logic              accept;
    logic              resp_keep;
    logic              resp_drop;

    // Queued words plus reads in flight never exceed DEPTH, so a kept response always has room.
    assign imem_req  = reset && (state == FETCH) && !redirect &&
                       (({1'b0, q_count} + {1'b0, outstanding}) < LIMIT);
    assign imem_addr = pc & ALIGN_MASK;
    assign accept    = imem_req && imem_rdy;
    assign resp_keep = imem_rvalid && (discard == '0);
    assign resp_drop = imem_rvalid && (discard != '0);
    assign q_din     = '{instr: imem_rdata, addr: tag_head};
    assign q_pop     = !q_empty && dec_ready && !redirect;

`ifdef FETCH_BYPASS_EN
    logic bypass;

    assign bypass    = resp_keep && !redirect && q_empty;
    assign dec_valid = !q_empty || bypass;
    assign dec_instr = bypass ? imem_rdata : (q_empty ? '0 : q_head.instr);
    assign dec_pc8   = bypass ? tag_head + ADDR_W'(PC_OFFSET) :
                       (q_empty ? '0 : q_head.addr + ADDR_W'(PC_OFFSET));
    assign q_push    = resp_keep && !(bypass && dec_ready);
`else
    assign dec_valid = !q_empty;
    assign dec_instr = q_empty ? '0 : q_head.instr;
    assign dec_pc8   = q_empty ? '0 : q_head.addr + ADDR_W'(PC_OFFSET);
    assign q_push    = resp_keep;
`endif

    // Redirect wins over everything; reads still in flight become discards.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        outstanding_next = outstanding + CNT_W'(accept) - CNT_W'(imem_rvalid);
        discard_next     = discard;
        if (redirect) begin
            pc_next      = redirect_pc & ALIGN_MASK;
            discard_next = outstanding - CNT_W'(imem_rvalid);
            state_next   = (discard_next != '0) ? FLUSH : FETCH;
        end else begin
            if (accept)    pc_next      = pc + ADDR_W'(PC_STEP);
            if (resp_drop) discard_next = discard - CNT_W'(1);
            if ((state == FLUSH) && (discard_next == '0)) state_next = FETCH;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            outstanding <= outstanding_next;
            discard     <= discard_next;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fq_entry_t)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .clear (redirect),
        .push  (q_push),
        .pop   (q_pop),
        .din   (q_din),
        .dout  (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // One tag per outstanding read, retired by every response whether kept or dropped.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (logic [ADDR_W-1:0])
    ) u_tags (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .push  (accept),
        .pop   (imem_rvalid),
        .din   (imem_addr),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (!reset)
        imem_rvalid |-> (outstanding != '0));
    tags_track_outstanding: assert property (@(posedge clk) disable iff (!reset)
        tag_count == outstanding);
    tag_present_on_response: assert property (@(posedge clk) disable iff (!reset)
        imem_rvalid |-> !tag_empty);
    tag_never_overflows: assert property (@(posedge clk) disable iff (!reset)
        accept |-> (!tag_full || imem_rvalid));
    queue_never_overflows: assert property (@(posedge clk) disable iff (!reset)
        (q_push && !redirect) |-> (!q_full || q_pop));

endmodule
